// File: rtl/loader_pkg.sv
// Shared definitions for the UART-driven instruction loader: FSM states,
// frame constants and the bytes-per-word helper.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA,
    ST_CHECK
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Byte offsets of the header fields, counted from the SYNC byte.
  localparam int OFS_ADDR_H = 1;
  localparam int OFS_ADDR_L = 2;
  localparam int OFS_CNT_H  = 3;
  localparam int OFS_CNT_L  = 4;
  localparam int OFS_DATA   = 5;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Assembles a data word from a byte stream, MSB first, and raises a one-cycle
// word_ready strobe in the cycle after the word's final byte was shifted in.
module loader_word_packer
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  input  logic [IDX_W-1:0]      byte_idx,
  output logic                  word_ready,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);

  // Shift each accepted byte into the low end; flag the word once its last byte lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      word_ready <= shift_en && (byte_idx == IDX_W'(BPW - 1));
      if (shift_en) begin
        word <= (word << 8) | DATA_WIDTH'(byte_in);
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Receives a framed program image over a UART byte stream and writes it into
// the instruction memory write port. Owns the frame FSM, address/count
// bookkeeping, running checksum and inter-byte timeout.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 12,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW    = ADDR_WIDTH + 2;
  localparam logic [RW-1:0] MEM_WORDS = RW'(1) << ADDR_WIDTH;

  state_t                state;
  logic [7:0]            hi_byte;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [7:0]            chk;
  logic [IDX_W-1:0]      byte_idx;
  logic [TO_W-1:0]       idle_cnt;

  logic                  byte_ok;
  logic                  shift_en;
  logic                  last_byte;
  logic                  timeout_hit;
  logic [15:0]           field16;
  logic [RW-1:0]         range_sum;
  logic                  addr_bad;
  logic                  cnt_bad;

  // Per-byte decode: header field value, address/range validity and timeout.
  always_comb begin
    // NOTE: every signal gets a default before any condition so no latch is inferred.
    byte_ok     = rx_valid && enable;
    shift_en    = byte_ok && (state == ST_DATA);
    last_byte   = (byte_idx == IDX_W'(BPW - 1));
    field16     = {hi_byte, rx_data};
    addr_bad    = (field16 >> ADDR_WIDTH) != 16'd0;
    range_sum   = RW'(addr) + RW'(field16);
    cnt_bad     = (field16 == 16'd0) || ((field16 >> (ADDR_WIDTH + 1)) != 16'd0) ||
                  (range_sum > MEM_WORDS);
    timeout_hit = (state != ST_IDLE) && !rx_valid &&
                  (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  end

  // Frame FSM with address, count, checksum, byte index and timeout bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hi_byte   <= '0;
      addr      <= '0;
      remaining <= '0;
      chk       <= '0;
      byte_idx  <= '0;
      idle_cnt  <= '0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE) begin
        idle_cnt <= rx_valid ? '0 : idle_cnt + TO_W'(1);
      end

      if (state != ST_IDLE && !enable) begin
        // Loader disarmed mid-frame: quiet abort, error untouched.
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (timeout_hit) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        error <= 1'b1;
      end else if (byte_ok) begin
        if (state inside {ST_ADDR_H, ST_ADDR_L, ST_CNT_H, ST_CNT_L, ST_DATA}) begin
          chk <= chk ^ rx_data;
        end
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= ST_ADDR_H;
              busy     <= 1'b1;
              error    <= 1'b0;
              chk      <= '0;
              byte_idx <= '0;
              idle_cnt <= '0;
            end
          end
          ST_ADDR_H: begin
            hi_byte <= rx_data;
            state   <= ST_ADDR_L;
          end
          ST_ADDR_L: begin
            if (addr_bad) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              addr  <= field16[ADDR_WIDTH-1:0];
              state <= ST_CNT_H;
            end
          end
          ST_CNT_H: begin
            hi_byte <= rx_data;
            state   <= ST_CNT_L;
          end
          ST_CNT_L: begin
            if (cnt_bad) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              remaining <= field16[ADDR_WIDTH:0];
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (last_byte) begin
              // The packer strobes wr_en next cycle; latch the target address alongside it.
              byte_idx  <= '0;
              wr_addr   <= addr;
              addr      <= addr + ADDR_WIDTH'(1);
              remaining <= remaining - (ADDR_WIDTH + 1)'(1);
              if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                state <= ST_CHECK;
              end
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
          ST_CHECK: begin
            if (rx_data == chk) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  loader_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en),
    .byte_in    (rx_data),
    .byte_idx   (byte_idx),
    .word_ready (wr_en),
    .word       (wr_data)
  );

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: nominal frame, range and count
// errors, bad checksum, timeout, enable abort, reset mid-word and a full
// 4096-word back-to-back image.
module tb_instruction_loader;

  localparam int TIMEOUT = 50;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr     = 0;
  int          n_done   = 0;
  logic [11:0] last_wr_addr = '0;

  instruction_loader #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (12),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for one clock; returns at the following negedge.
  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] bytes[$]);
    foreach (bytes[i]) put(bytes[i]);
  endtask

  // Write-port scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      last_wr_addr = wr_addr;
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.a));
        check("wr_data", 64'(wr_data), 64'(e.d));
      end
    end
    if (done) n_done++;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  chk;
    logic [7:0]  bt;
    logic [31:0] w;
    int          waited;
    int          done_before;

    rst_n    = 1'b0;
    enable   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_error", 64'(error), 64'd0);

    // Nominal two-word frame at 101; CHK = 0x56
    exp_q.push_back('{12'd101, 32'hDEADBEEF});
    exp_q.push_back('{12'd102, 32'h00000013});
    q = '{8'hA5, 8'h00, 8'h65, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(q);
    check("nom_wr0_en",   64'(wr_en),   64'd1);
    check("nom_wr0_addr", 64'(wr_addr), 64'd101);
    check("nom_wr0_data", 64'(wr_data), 64'hDEADBEEF);
    check("nom_busy",     64'(busy),    64'd1);
    q = '{8'h00, 8'h00, 8'h00, 8'h13};
    send(q);
    check("nom_wr1_en",   64'(wr_en),   64'd1);
    check("nom_wr1_addr", 64'(wr_addr), 64'd102);
    check("nom_wr1_data", 64'(wr_data), 64'h00000013);
    put(8'h56);
    check("nom_done",  64'(done),  64'd1);
    check("nom_error", 64'(error), 64'd0);
    check("nom_busy0", 64'(busy),  64'd0);
    gap(1);
    check("nom_done_pulse", 64'(done), 64'd0);
    check("nom_wr_count",   64'(n_wr), 64'd2);

    // Range overflow: start 0x0FFF, count 2
    q = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02};
    send(q);
    check("rng_error", 64'(error), 64'd1);
    check("rng_busy",  64'(busy),  64'd0);
    check("rng_wr_en", 64'(wr_en), 64'd0);
    gap(3);
    check("rng_no_wr", 64'(n_wr), 64'd2);

    // Count zero; the SYNC byte clears the sticky error first
    put(8'hA5);
    check("cnt0_err_cleared", 64'(error), 64'd0);
    check("cnt0_busy",        64'(busy),  64'd1);
    q = '{8'h00, 8'h10, 8'h00, 8'h00};
    send(q);
    check("cnt0_error", 64'(error), 64'd1);
    check("cnt0_busy0", 64'(busy),  64'd0);
    gap(3);
    check("cnt0_no_wr", 64'(n_wr), 64'd2);

    // Bad checksum: good CHK is 0x29, send 0x28
    exp_q.push_back('{12'h020, 32'h12345678});
    done_before = n_done;
    q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h28};
    send(q);
    check("badchk_error", 64'(error), 64'd1);
    check("badchk_done",  64'(done),  64'd0);
    check("badchk_busy",  64'(busy),  64'd0);
    gap(2);
    check("badchk_wr_count", 64'(n_wr),   64'd3);
    check("badchk_no_done",  64'(n_done), 64'(done_before));

    // Timeout after two data bytes
    q = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'hAA, 8'hBB};
    send(q);
    gap(10);
    check("to_busy_mid",  64'(busy),  64'd1);
    check("to_error_mid", 64'(error), 64'd0);
    waited = 0;
    while (!error && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("to_error",  64'(error), 64'd1);
    check("to_busy0",  64'(busy),  64'd0);
    check("to_window", 64'(waited >= 39 && waited <= 41), 64'd1);
    check("to_no_wr",  64'(n_wr), 64'd3);

    // Valid frame after timeout; CHK = 0x34
    exp_q.push_back('{12'h031, 32'h01020304});
    q = '{8'hA5, 8'h00, 8'h31, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h34};
    send(q);
    check("rec_done",  64'(done),  64'd1);
    check("rec_error", 64'(error), 64'd0);
    gap(2);
    check("rec_wr_count", 64'(n_wr), 64'd4);

    // Enable dropped mid-DATA
    q = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h02, 8'h11, 8'h22};
    send(q);
    enable = 1'b0;
    put(8'h33);
    check("abort_busy",  64'(busy),  64'd0);
    check("abort_error", 64'(error), 64'd0);
    put(8'h44);
    gap(3);
    enable = 1'b1;
    gap(2);
    check("abort_no_wr", 64'(n_wr),  64'd4);
    check("abort_busy2", 64'(busy),  64'd0);

    // Reset asserted on the cycle of a word's final byte
    q = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    send(q);
    rx_valid = 1'b1;
    rx_data  = 8'hDD;
    rst_n    = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_en",   64'(wr_en),   64'd0);
    check("rst_mid_busy",    64'(busy),    64'd0);
    check("rst_mid_done",    64'(done),    64'd0);
    check("rst_mid_error",   64'(error),   64'd0);
    check("rst_mid_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_mid_wr_data", 64'(wr_data), 64'd0);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    gap(2);
    check("rst_mid_no_wr", 64'(n_wr), 64'd4);

    // Full 4096-word image at address 0, one byte every clock
    done_before = n_done;
    chk = 8'h00;
    put(8'hA5);
    q = '{8'h00, 8'h00, 8'h10, 8'h00};
    foreach (q[i]) begin
      chk ^= q[i];
      put(q[i]);
    end
    for (int i = 0; i < 4096; i++) begin
      w = 32'hA5A5_0000 ^ 32'(i * 7);
      exp_q.push_back('{12'(i), w});
      for (int k = 3; k >= 0; k--) begin
        bt = w[k*8 +: 8];
        chk ^= bt;
        put(bt);
      end
    end
    put(chk);
    check("full_done",  64'(done),  64'd1);
    check("full_error", 64'(error), 64'd0);
    gap(3);
    check("full_wr_count",  64'(n_wr),          64'd4100);
    check("full_last_addr", 64'(last_wr_addr),  64'hFFF);
    check("full_done_cnt",  64'(n_done),        64'(done_before + 1));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
